// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the round-robin counter scheduler.
// The state encoding lives here so the top and any future observers
// agree on what IDLE/RUN/DONE look like on the wire.
package counter_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder. Searches req upward starting
// at index ptr, wrapping past NREQ-1 back to 0, and returns the first
// requester found as a one-hot vector.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  // Walk the requesters in priority order; the first hit wins and
  // blocks every lower-priority requester behind it.
  always_comb begin
    int idx;
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler sharing one up-counter between NREQ requesters.
// A winner is granted from IDLE, the counter runs 0..tc during RUN, and
// a single DONE cycle pulses done[owner] before returning to IDLE.
// Optional build macro: COUNTER_SCHED_ABORT_EN lets the owner cancel a
// run by dropping its request while in RUN (no done pulse in that case).
module counter_rr_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t     state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic [NREQ-1:0]  win;
  logic             any;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    ptr_after_owner;
  logic             abort_run;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // Convert the one-hot winner into an index for len slicing and owner tracking.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

  // Priority resumes just past whoever owned the counter last.
  always_comb begin
    if (owner_q == PW'(NREQ - 1)) ptr_after_owner = '0;
    else                          ptr_after_owner = owner_q + PW'(1);
  end

  // Owner cancellation is only possible when the abort feature is built in.
  always_comb begin
`ifdef COUNTER_SCHED_ABORT_EN
    abort_run = !req[owner_q];
`else
    abort_run = 1'b0;
`endif
  end

  // Next-state logic: grant from IDLE, count in RUN, release after DONE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    tc_d    = tc_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_RUN;
          gnt_d   = win;
          owner_d = win_idx;
          tc_d    = len[int'(win_idx)*WIDTH +: WIDTH];
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (abort_run) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          count_d = '0;
          ptr_d   = ptr_after_owner;
        end else if (count_q == tc_q) begin
          state_d = ST_DONE;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        count_d = '0;
        ptr_d   = ptr_after_owner;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // State, pointer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      tc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      tc_q    <= tc_d;
      count_q <= count_d;
    end
  end

  // Outputs come straight from registers or from a state decode.
  always_comb begin
    gnt   = gnt_q;
    count = count_q;
    done  = (state_q == ST_DONE) ? gnt_q : '0;
    busy  = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Bench for counter_rr_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a run-length reference model.
module tb_counter_rr_scheduler;
  import counter_sched_pkg::*;

  localparam int NREQ  = NREQ_DEF;
  localparam int WIDTH = WIDTH_DEF;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;
  logic                  busy;

  int passed;
  int total;

  // Reference model: owner (-1 when idle), cycles elapsed since grant,
  // latched terminal count, and rotating priority pointer.
  int m_owner;
  int m_e;
  int m_tc;
  int m_ptr;

  counter_rr_scheduler #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .count (count),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelEdge(input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] ln,
                           input logic rst);
    bit abort;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_e     = 0;
      m_tc    = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < NREQ; i++) begin
        int idx;
        idx = (m_ptr + i) % NREQ;
        if (m_owner < 0 && rq[idx]) begin
          m_owner = idx;
          m_tc    = int'(ln[idx*WIDTH +: WIDTH]);
          m_e     = 0;
        end
      end
    end else begin
      abort = 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
      abort = (m_e <= m_tc) && !rq[m_owner];
`endif
      if (abort) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_e = m_e + 1;
        if (m_e > m_tc + 1) begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
  endtask

  // Compare every output against what the model says this cycle should show.
  task automatic checkOutput();
    logic [NREQ-1:0]  e_gnt;
    logic [WIDTH-1:0] e_count;
    logic [NREQ-1:0]  e_done;
    logic             e_busy;
    if (m_owner < 0) begin
      e_gnt   = '0;
      e_count = '0;
      e_done  = '0;
      e_busy  = 1'b0;
    end else begin
      e_gnt   = NREQ'(1) << m_owner;
      e_count = WIDTH'((m_e < m_tc) ? m_e : m_tc);
      e_done  = (m_e == m_tc + 1) ? e_gnt : '0;
      e_busy  = 1'b1;
    end
    checkOne("gnt",   32'(gnt),   32'(e_gnt));
    checkOne("count", 32'(count), 32'(e_count));
    checkOne("done",  32'(done),  32'(e_done));
    checkOne("busy",  32'(busy),  32'(e_busy));
  endtask

  // Drive one cycle of inputs, clock it in, then check one time unit later.
  task automatic applyStimulus(input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] ln,
                               input logic rst);
    req   = rq;
    len   = ln;
    reset = rst;
    @(posedge clk);
    modelEdge(rq, ln, rst);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [NREQ-1:0]       r_req;
    logic [NREQ*WIDTH-1:0] r_len;
    passed  = 0;
    total   = 0;
    m_owner = -1;
    m_ptr   = 0;
    m_e     = 0;
    m_tc    = 0;
    req     = '0;
    len     = '0;
    reset   = 1'b1;
    #2;

    // Reset state.
    applyStimulus('0, '0, 1'b1);
    applyStimulus('0, '0, 1'b1);

    // Single request, len0=3.
    for (int i = 0; i < 7; i++) applyStimulus(4'b0001, 16'h0003, 1'b0);
    applyStimulus('0, '0, 1'b0);

    // Full contention, all len=0.
    applyStimulus('0, '0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(4'b1111, 16'h0000, 1'b0);

    // Pointer rotation: serve requester 2, then 1001 competes.
    applyStimulus('0, '0, 1'b1);
    applyStimulus(4'b0100, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(4'b1001, 16'h0000, 1'b0);

    // Len change during RUN does not shorten the run.
    applyStimulus('0, '0, 1'b1);
    applyStimulus(4'b0001, 16'h0003, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(4'b0001, 16'h0001, 1'b0);

    // Reset mid-run while count=2.
    applyStimulus('0, '0, 1'b1);
    applyStimulus(4'b0001, 16'h0005, 1'b0);
    applyStimulus(4'b0001, 16'h0005, 1'b0);
    applyStimulus(4'b0001, 16'h0005, 1'b0);
    checkOne("midrun_count", 32'(count), 32'd2);
    applyStimulus(4'b0001, 16'h0005, 1'b1);
    checkOne("reset_gnt", 32'(gnt), 32'd0);
    // Pointer must be back at 0: requester 0 beats requester 1.
    applyStimulus(4'b0011, 16'h0000, 1'b0);
    checkOne("reset_ptr", 32'(gnt), 32'b0001);

    // Requester 0 drops its request while count=1, requester 1 pending.
    applyStimulus('0, '0, 1'b1);
    applyStimulus(4'b0011, 16'h0023, 1'b0);
    applyStimulus(4'b0011, 16'h0023, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(4'b0010, 16'h0023, 1'b0);

    // Random traffic with held request levels and rare resets.
    applyStimulus('0, '0, 1'b1);
    r_req = '0;
    r_len = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r_req = NREQ'($urandom);
      if ($urandom_range(0, 2) == 0) r_len = (NREQ*WIDTH)'($urandom) & {NREQ{4'h7}};
      applyStimulus(r_req, r_len, ($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_rr_scheduler.md
# counter_rr_scheduler

Round-robin scheduler that shares one up-counter between `NREQ` requesters. Each requester asks for a run of the counter to its own terminal count. The block grants exactly one owner at a time, sequences the count from 0 to that owner's terminal value, and returns a one-cycle completion pulse. It sits between the requesting control blocks and the counter datapath and owns the counter register.

## Interface
- `NREQ`, default 4: number of requesters, at least 2.
- `WIDTH`, default 4: counter and terminal-count width.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: per-requester run request, level.
- `len`  in  NREQ*WIDTH: per-requester terminal count; slice i is `len[i*WIDTH +: WIDTH]`.
- `gnt`  out  NREQ: one-hot owner of the counter, all-zero when idle.
- `count`  out  WIDTH: current counter value.
- `done`  out  NREQ: one-cycle completion pulse to the owner.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE
  - `count`=0, `gnt`=0, `done`=0.
  - If any `req` bit is high, select the winner by rotating priority starting at pointer `ptr`, searching upward with wrap.
  - Next edge: `gnt`=onehot(winner), latch `tc`=len slice of winner, `count`=0, go to RUN.
- RUN
  - If `count`==`tc`: next edge goes to DONE with `count` held.
  - Otherwise `count` increments by 1 per cycle.
- DONE
  - `done`[owner]=1 and `gnt` stays asserted, for exactly one cycle.
  - Next edge: go to IDLE, clear `gnt`/`count`/`done`, and set `ptr`=(owner+1) mod NREQ.
- `len` is sampled only at grant; later changes do not affect the current run.
- `len`=0 gives one RUN cycle at count 0, then DONE.
- `req` is not required to stay high after grant unless abort is compiled in (see Configuration).
- Arithmetic is WIDTH-bit unsigned. `count` never exceeds `tc`, so it never wraps.
- A requester holding `req` high through DONE competes again in IDLE at its rotated priority.

## Timing
- Reset values: state=IDLE, `ptr`=0, `gnt`=0, `count`=0, `done`=0, `busy`=0.
- Reset applied mid-run returns to the reset values at the next edge, with no `done` pulse.
- Request to grant: `req` high before edge k gives `gnt` high after edge k.
- Grant length: `gnt` is high for `tc`+2 cycles (`tc`+1 RUN cycles plus 1 DONE cycle).
- `done` is coincident with the last `gnt` cycle.
- There is exactly one IDLE cycle between consecutive grants, so back-to-back throughput is one run per `tc`+3 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from `req` to `gnt`.

## Configuration
- `COUNTER_SCHED_ABORT_EN` defined:
  - In RUN, if `req`[owner] is low, the next edge goes to IDLE with `gnt`=0, `count`=0 and no `done` pulse.
  - `ptr` advances to owner+1.
  - DONE is never aborted.
- `COUNTER_SCHED_ABORT_EN` undefined:
  - `req` is ignored after grant.
  - The run always completes and `done` is always pulsed.

## Structure
- Package `counter_sched_pkg` holds:
  - the state typedef (IDLE/RUN/DONE encoding);
  - the default constants `NREQ_DEF`=4 and `WIDTH_DEF`=4.
- Sub-module `rr_pick` is a combinational rotating-priority encoder: inputs `req` and `ptr`, outputs one-hot `win` and `any`.
- The FSM, `tc` register and counter stay in the top module.

## Test plan
- Single request, from reset: `req`=0001, len0=3.
  - `gnt`=0001 after edge 1.
  - `count` is 0,1,2,3 after edges 1–4.
  - `done`=0001 after edge 5 only.
  - `gnt`=0 and `busy`=0 after edge 6.
- Full contention, from reset: `req`=1111, all len=0.
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 2 cycles, with 1 idle cycle between grants.
- Pointer rotation: serve requester 2, then `req`=1001.
  - Next grant goes to 3, then 0.
- Len change: len0 changed from 3 to 1 during RUN.
  - The run still reaches 3.
  - `done` is still issued at 3+2 cycles after grant.
- Reset mid-run: reset asserted while `count`=2.
  - Next edge: all outputs 0, no `done` pulse, `ptr`=0.
- Abort, built with `COUNTER_SCHED_ABORT_EN`: `req`[0] dropped while `count`=1.
  - Next edge: `gnt`=0, no `done` pulse.
  - A pending `req`[1] is granted one cycle later.
  - Without the macro, the same stimulus completes the run to `tc` and pulses `done`.
